// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam int          DEF_ADDR_W        = 32;
    localparam int          DEF_DATA_W        = 32;
    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEADBEEF;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a contested request goes to the master that was not served last.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] pick
);
    always_comb begin
        pick = 2'b00;
        case (valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_grant ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory slave between two valid/ready masters,
// with a per-transaction timeout that returns a fixed error word.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(DEF_TIMEOUT_RDATA)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                timeout_err,
    input  logic                err_clr
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    logic             last_grant;   // 0: m0 served last, 1: m1 served last
    logic [CNT_W-1:0] tcnt;
    logic [1:0]       pick;
    logic             busy, sel, cur_valid, done, tmo;

    rr_pick2 u_pick (
        .valid      ({m1_valid, m0_valid}),
        .last_grant (last_grant),
        .pick       (pick)
    );

    assign busy      = (state != IDLE);
    assign sel       = (state == BUSY1);
    // A dropped master valid gates everything, so an aborted request never completes.
    assign cur_valid = busy && (sel ? m1_valid : m0_valid);
    assign done      = cur_valid && s_ready;
    assign tmo       = cur_valid && !s_ready && (tcnt == CNT_LAST);

    assign s_valid = cur_valid;
    assign s_addr  = !busy ? '0 : (sel ? m1_addr  : m0_addr);
    assign s_wdata = !busy ? '0 : (sel ? m1_wdata : m0_wdata);
    assign s_wstrb = !busy ? '0 : (sel ? m1_wstrb : m0_wstrb);

    assign m0_ready = (state == BUSY0) && (done || tmo);
    assign m1_ready = (state == BUSY1) && (done || tmo);
    assign m0_rdata = (state == BUSY0) ? (tmo ? TIMEOUT_RDATA : s_rdata) : '0;
    assign m1_rdata = (state == BUSY1) ? (tmo ? TIMEOUT_RDATA : s_rdata) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            tcnt        <= '0;
            last_grant  <= 1'b1;
        end else begin
            if (tmo)          timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (pick[0]) begin
                        state <= BUSY0;
                        grant <= 2'b01;
                    end else if (pick[1]) begin
                        state <= BUSY1;
                        grant <= 2'b10;
                    end
                end
                default: begin
                    // Every exit returns to IDLE so a stale valid is never re-issued.
                    if (!cur_valid) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (done || tmo) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_grant <= sel;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master round-robin arbiter that shares one single-port memory slave (the BRAM controller) between two valid/ready requesters, e.g. CPU and a UART loader/DMA engine.
- Forwards the granted master's request to the slave and returns the slave's ready and rdata to that master only.
- A per-transaction timeout returns a fixed error word, so a hung slave cannot stall the system.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 16, BUSY cycles without s_ready before the arbiter aborts; must be >= 2.
- TIMEOUT_RDATA, 32'hDEADBEEF, rdata returned to the master on timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  master 0 request.
- m0_ready  out  1  master 0 completion pulse.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_wstrb  in  DATA_W/8  master 0 strobe; 0 means read.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as the m0_* ports, for master 1.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  DATA_W/8  slave strobe.
- s_rdata  in  DATA_W  slave read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  sticky flag, set on any timeout.
- err_clr  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant=00, timeout_err=0, timeout counter=0, last_grant=M1 so m0 wins the first tie.
  - All ready, valid and rdata outputs are 0.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - s_valid=0.
  - Only m0_valid: go to BUSY0. Only m1_valid: go to BUSY1.
  - Both valid: grant the master not equal to last_grant.
  - Neither valid: stay in IDLE.
  - Arbitration costs exactly 1 cycle; the request reaches the slave the cycle after the decision.
- BUSYn:
  - s_valid/s_addr/s_wdata/s_wstrb are driven combinationally from master n.
  - mn_ready = s_ready; mn_rdata = s_rdata. The other master sees ready=0 and rdata=0.
  - When s_ready=1: last_grant<=n, go to IDLE.
- Minimum turnaround: the arbiter always passes through one IDLE cycle between transactions, even back-to-back. This keeps a stale valid from being re-issued to the slave.
- Timeout:
  - The counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES-1 with s_ready=0:
    - mn_ready=1 for that cycle and mn_rdata=TIMEOUT_RDATA.
    - timeout_err<=1, last_grant<=n, go to IDLE.
  - If s_ready and the timeout occur in the same cycle, s_ready wins: normal completion, no error.
- Master abort: if the granted mn_valid drops while in BUSYn before s_ready arrives:
  - go to IDLE next cycle with no ready pulse; last_grant is unchanged.
  - This is a protocol violation; the arbiter only guarantees it does not hang.
- Non-granted master: may hold valid indefinitely and is served next (round-robin gives a bound of one foreign transaction).
- err_clr=1 clears timeout_err; a timeout in the same cycle wins (flag stays 1).
- Reset asserted mid-transaction: the state is abandoned and s_valid drops immediately. No ready pulse is issued.
- Writes: the arbiter does not interpret wstrb; it is passed through unchanged.

Decomposition:
- Shared package mem_bus_pkg:
  - enum arb_state_t {IDLE, BUSY0, BUSY1}
  - defaults for ADDR_W/DATA_W
  - TIMEOUT_RDATA constant
- Natural sub-module: rr_pick2, a combinational round-robin picker (valids, last_grant -> one-hot grant).
- The FSM, timeout counter and bus mux stay in mem_arbiter.

Test Plan:
- Single read: m0 reads addr 0x10 with the slave returning 0x4 after 2 cycles. Expect:
  - s_valid one cycle after m0_valid.
  - m0_ready pulse with m0_rdata=0x4.
  - m1_ready stays 0; grant returns to 00.
- Simultaneous requests held continuously, m0 read 0x0 and m1 write 0x8 (data 0xA5A5A5A5, wstrb 1111). Expect:
  - service order m0, m1, m0, m1 (grant 01,10,01,10);
  - one IDLE cycle between each transaction;
  - the slave sees the m1 write exactly once per grant.
- Starvation check: m1 holds valid while m0 issues 5 back-to-back reads. Expect m1 granted no later than the second transaction.
- Timeout: slave never asserts ready while m1 reads 0x20. Expect:
  - m1_ready in BUSY cycle 16 with m1_rdata=0xDEADBEEF;
  - timeout_err=1;
  - err_clr pulse returns timeout_err to 0.
- Edge collisions:
  - s_ready arriving in the same cycle as the timeout gives normal completion with timeout_err=0.
  - err_clr coinciding with a timeout leaves timeout_err=1.
- Reset mid-BUSY0: assert reset between clock edges. Expect:
  - s_valid and grant go to 0 immediately;
  - after release, a simultaneous request pair grants m0 first.
